// File: rtl/prbs8_pkg.sv
// Shared definitions for the 8-bit PRBS generator/checker pair.
// Fibonacci LFSR, taps 7,5,4,2, feedback shifted into bit 0.
package prbs8_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs8_state_e;

  localparam logic [7:0] TAP_MASK = 8'hB4;

  // Next transmitted bit for LFSR state r.
  function automatic logic prbs8_fb(input logic [7:0] r);
    return ^(r & TAP_MASK);
  endfunction

endpackage

// File: rtl/prbs8_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), inc (count one), clr (zero, wins over inc),
//        count (holds at all-ones).
module prbs8_sat_counter
  import prbs8_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs8_checker.sv
// Serial PRBS8 checker: self-synchronises to the generator stream, declares
// lock, then counts bit errors against a locally regenerated reference.
// Ports: clk, rst (sync, active-high), din/din_valid (serial input),
//        clr (zero the counters), locked, err_pulse (one cycle per error),
//        err_count, bit_count (saturating, counted only while locked).
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned ERR_W      = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned MATCH_W = 8;
  localparam int unsigned WIN_W   = 16;
  localparam int unsigned FILL_W  = 3;

  prbs8_state_e       state;
  logic [7:0]         r;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [WIN_W-1:0]   win_bits;
  logic [WIN_W-1:0]   win_err;

  logic pred;
  logic bit_err_c;
  logic lock_bit_c;

  // Prediction of the incoming bit from the current reference state.
  assign pred       = prbs8_fb(r);
  assign lock_bit_c = din_valid && (state == LOCKED);
  assign bit_err_c  = lock_bit_c && (din != pred);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      r         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (din_valid) begin
        case (state)
          FILL: begin
            r        <= {r[6:0], din};
            fill_cnt <= fill_cnt + FILL_W'(1);
            if (fill_cnt == FILL_W'(7)) begin
              state     <= VERIFY;
              match_cnt <= '0;
            end
          end
          VERIFY: begin
            r <= {r[6:0], din};
            // An all-zero register predicts zeros forever; never trust it.
            if ((din == pred) && (r != 8'h00)) begin
              if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                win_bits <= '0;
                win_err  <= '0;
              end else begin
                match_cnt <= match_cnt + MATCH_W'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Free-run on the prediction so a single line error is counted once.
            r         <= {r[6:0], pred};
            err_pulse <= bit_err_c;
            if (bit_err_c && (win_err == WIN_W'(ERR_THRESH - 1))) begin
              state     <= FILL;
              locked    <= 1'b0;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else if (win_bits == WIN_W'(WINDOW - 1)) begin
              win_bits <= '0;
              win_err  <= '0;
            end else begin
              win_bits <= win_bits + WIN_W'(1);
              win_err  <= win_err + WIN_W'(bit_err_c);
            end
          end
          default: begin
            state  <= FILL;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  prbs8_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bit_err_c),
    .clr   (clr),
    .count (err_count)
  );

  prbs8_sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lock_bit_c),
    .clr   (clr),
    .count (bit_count)
  );

endmodule

// File: tb/tb_prbs8_checker.sv
// Scoreboard bench for prbs8_checker: stimulus pushes per-cycle expected
// outputs, a negedge monitor pops and compares. A second instance with
// ERR_W=4 runs on the same stimulus to observe err_count saturation.
module tb_prbs8_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        din_valid;
  logic        clr;
  logic        locked, locked4;
  logic        err_pulse, err_pulse4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
  logic [31:0] bit_count, bit_count4;

  always #5 clk = ~clk;

  prbs8_checker dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  prbs8_checker #(.ERR_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clr       (clr),
    .locked    (locked4),
    .err_pulse (err_pulse4),
    .err_count (err_count4),
    .bit_count (bit_count4)
  );

  typedef struct packed {
    logic        locked;
    logic        pulse;
    logic [15:0] err;
    logic [3:0]  err4;
    logic [31:0] bits;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Expectation state held by the stimulus side.
  logic [7:0]  g;
  logic        e_locked;
  int          e_run;
  int          e_k;
  logic [15:0] e_err;
  logic [3:0]  e_err4;
  logic [31:0] e_bits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("locked",     32'(locked),     32'(e.locked));
      chk("err_pulse",  32'(err_pulse),  32'(e.pulse));
      chk("err_count",  32'(err_count),  32'(e.err));
      chk("bit_count",  bit_count,       e.bits);
      chk("locked4",    32'(locked4),    32'(e.locked));
      chk("err_pulse4", 32'(err_pulse4), 32'(e.pulse));
      chk("err_count4", 32'(err_count4), 32'(e.err4));
    end
  end

  // One clock of stimulus. inv flips a generator bit, zero forces din=0
  // without advancing the generator, cnt marks bits that build toward lock,
  // lose marks the error expected to drop lock.
  task automatic step(input logic r_rst, input logic v, input logic inv,
                      input logic zero, input logic cnt, input logic lose,
                      input logic c);
    logic b;
    logic fb;
    exp_t e;
    logic ep;
    b = 1'($urandom_range(0, 1));
    if (v && zero) begin
      b = 1'b0;
    end else if (v) begin
      fb = g[7] ^ g[5] ^ g[4] ^ g[2];
      g  = {g[6:0], fb};
      b  = fb ^ inv;
    end
    @(negedge clk);
    rst = r_rst; din_valid = v; din = b; clr = c;
    @(posedge clk);
    ep = 1'b0;
    if (r_rst) begin
      e_locked = 1'b0; e_run = 0; e_k = 0;
      e_err = '0; e_err4 = '0; e_bits = '0;
    end else begin
      if (v && e_locked) begin
        if (e_bits != 32'hFFFF_FFFF) e_bits = e_bits + 32'd1;
        if (inv) begin
          ep = 1'b1;
          if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
          if (e_err4 != 4'hF) e_err4 = e_err4 + 4'd1;
          if (lose) begin
            e_locked = 1'b0;
            e_run    = 0;
          end
        end
        e_k++;
      end else if (v && cnt) begin
        e_run++;
        if (e_run == 24) begin
          e_locked = 1'b1;
          e_k      = 0;
        end
      end
      if (c) begin
        e_err = '0; e_err4 = '0; e_bits = '0;
      end
    end
    e = '{locked: e_locked, pulse: ep, err: e_err, err4: e_err4, bits: e_bits};
    sb.push_back(e);
  endtask

  task automatic clean();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    g = 8'hFF;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; clr = 1'b0;
    g = 8'hFF;
    e_locked = 1'b0; e_run = 0; e_k = 0;
    e_err = '0; e_err4 = '0; e_bits = '0;

    // Clean stream from reset: lock on bit 24, 976 bits counted.
    do_reset();
    repeat (1000) clean();

    // Single inverted bit while locked.
    repeat (100) clean();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (200) clean();

    // Four errors inside one window drop lock, then relock.
    do_reset();
    for (int i = 0; i < 200 && !(e_locked && e_k == 74); i++) clean();
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, (j == 3), 1'b0);
      clean();
    end
    repeat (100) clean();

    // All-zero input never locks; clean stream afterwards does.
    do_reset();
    repeat (500) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (100) clean();

    // Sparse din_valid.
    do_reset();
    repeat (400) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // One error per window for 20 windows, then clr coincident with an error.
    do_reset();
    for (int i = 0; i < 100 && !e_locked; i++) clean();
    for (int w = 0; w < 20; w++) begin
      for (int i = 0; i < 64; i++) begin
        step(1'b0, 1'b1, (e_k % 64 == 5), 1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    for (int i = 0; i < 64 && (e_k % 64 != 5); i++) clean();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) clean();

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
